// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and MDU state type shared by the ALU/MDU slice
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_NOR  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/mdu_core.sv
// rtl/mdu_core.sv - iterative radix-2 multiply/divide unit with HI/LO result registers
module mdu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    md_state_t        state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;

    logic             op_div;
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign op_div    = (md_op == MD_DIVU) || (md_op == MD_DIV);
    assign op_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
    assign a_neg     = op_signed & a[WIDTH-1];
    assign b_neg     = op_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // Multiply keeps the product in {acc, qr} with the multiplier shifting out of qr;
    // divide keeps the partial remainder in acc and shifts quotient bits into qr.
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   acc_n;
    logic [WIDTH-1:0]   qr_n;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    assign add_sum  = {1'b0, acc} + {1'b0, opnd};
    assign shifted  = {acc, qr[WIDTH-1]};
    assign div_ge   = shifted >= {1'b0, opnd};
    assign div_diff = shifted[WIDTH-1:0] - opnd;
    assign prod     = {acc, qr};
    assign prod_fix = neg_q ? -prod : prod;

    always_comb begin
        acc_n = acc;
        qr_n  = qr;
        if (is_div) begin
            acc_n = div_ge ? div_diff : shifted[WIDTH-1:0];
            qr_n  = {qr[WIDTH-2:0], div_ge};
        end else if (qr[0]) begin
            acc_n = add_sum[WIDTH:1];
            qr_n  = {add_sum[0], qr[WIDTH-1:1]};
        end else begin
            acc_n = {1'b0, acc[WIDTH-1:1]};
            qr_n  = {acc[0], qr[WIDTH-1:1]};
        end
    end

    assign busy = (state != MD_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            acc    <= '0;
            qr     <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (hi_we) hi <= a;
                    if (lo_we) lo <= a;
                    if (md_start) begin
                        is_div <= op_div;
                        cnt    <= '0;
                        if (op_div && (b == '0)) begin
                            // Divide by zero: FIX passes these through untouched.
                            acc   <= a;
                            qr    <= '1;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= MD_FIX;
                        end else begin
                            acc   <= '0;
                            qr    <= op_div ? a_mag : b_mag;
                            opnd  <= op_div ? b_mag : a_mag;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                            state <= MD_RUN;
                        end
                    end
                end
                MD_RUN: begin
                    acc <= acc_n;
                    qr  <= qr_n;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST_STEP) state <= MD_FIX;
                end
                MD_FIX: begin
                    if (is_div) begin
                        hi <= neg_r ? -acc : acc;
                        lo <= neg_q ? -qr : qr;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    state <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - execute-stage combinational ALU with an iterative multiply/divide unit
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_control,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             lt_u;
    logic             lt_s;

    assign sum     = a + b;
    assign diff    = a + ~b + ONE;
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    assign lt_u    = a < b;
    assign lt_s    = $signed(a) < $signed(b);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (alu_control)
            ALU_ADD: begin
                result   = sum;
                overflow = add_ovf;
            end
            ALU_SUB: begin
                result   = diff;
                overflow = sub_ovf;
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, lt_u};
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, lt_s};
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

    mdu_core #(
        .WIDTH(WIDTH)
    ) u_mdu (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .md_start (md_start),
        .md_op    (md_op),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised successor to the core 32-bit datapath ALU. It keeps the single-cycle combinational operation set and encoding, adds a signed-overflow flag, and adds an iterative multiply/divide unit with HI/LO result registers and a start/busy/done handshake. It sits in the execute stage. The controller stalls on `busy` and reads HI/LO for `mfhi`/`mflo`.

## Interface
Parameters:
- `WIDTH`, 32: datapath width; must be at least 4.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `a`, `b` in WIDTH: operands, shared by the ALU and the MDU.
- `alu_control` in 3: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 sltu, 111 slt.
- `result` out WIDTH: combinational ALU result.
- `zero` out 1: high when `result` == 0.
- `overflow` out 1: signed overflow of add/sub; 0 for all other ops.
- `md_start` in 1: request an MDU operation.
- `md_op` in 2: 00 multu, 01 mult, 10 divu, 11 div.
- `hi_we`, `lo_we` in 1: direct HI/LO write (mthi/mtlo); data taken from `a`.
- `busy` out 1: MDU operation in progress.
- `done` out 1: one-cycle pulse; HI/LO hold the new result.
- `hi`, `lo` out WIDTH: result registers.

## Operation
- ALU path is purely combinational and identical for any WIDTH.
  - sub is `a + ~b + 1`.
  - sltu and slt results are zero-extended to WIDTH bits.
  - slt uses a true signed compare: `(a<b)` signed, not the sum sign bit.
- `overflow` is raised for add when both operands have the same sign and the sum sign differs; for sub when the operand signs differ and the difference sign differs from `a`.
- MDU state machine: IDLE, RUN, FIX.
  - IDLE with `md_start` = 1: latch the operation and operand magnitudes (absolute value for signed ops), record the result signs, clear the counter, go to RUN.
  - Divide with `b` == 0: go straight to FIX.
  - RUN: one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide). After WIDTH steps, go to FIX.
  - FIX: apply sign correction.
    - Product: negate the 2·WIDTH-bit product if the operand signs differ.
    - Quotient: negate if the operand signs differ.
    - Remainder: takes the dividend's sign.
    - Write HI (product upper half or remainder) and LO (product lower half or quotient), pulse `done`, return to IDLE.
- Divide by zero: LO = all ones, HI = `a` as latched.
- Signed divide of most-negative by −1: LO = most-negative (wraps), HI = 0.
- `busy` is high in RUN and FIX.
- While busy:
  - `md_start` is ignored (not queued).
  - `hi_we`/`lo_we` are ignored.
- In IDLE, `hi_we`/`lo_we` write `a` to HI/LO at the next edge. If `md_start` arrives in the same cycle, both the write and the start take effect; the MDU result later overwrites.
- Operands are latched at start; later changes to `a`/`b` do not affect the running operation.

## Timing
- Reset (`rst_n` = 0 at an edge): state IDLE, `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, counter 0. Reset overrides everything, including mid-operation: the operation is aborted and no `done` is issued.
- ALU path: zero-cycle latency; `result`, `zero` and `overflow` are valid in the same cycle as the inputs.
- Count the cycle in which `md_start` is sampled as cycle 0:
  - `busy` is high in cycles 1 through WIDTH+1.
  - `done` is high in cycle WIDTH+2, with new `hi`/`lo` valid in the same cycle.
  - Divide by zero: `busy` is high in cycle 1 only; `done` is high in cycle 2.
- A new `md_start` is accepted in the `done` cycle, since the block is back in IDLE.
- The step counter is clog2(WIDTH)+1 bits wide and has no wrap-around within an operation.

## Structure
- Package `alu_pkg`: ALU opcode localparams, MDU opcode localparams, and the MDU state enum (IDLE/RUN/FIX).
- Sub-module `mdu_core`: the iterative multiply/divide FSM, its datapath and the HI/LO registers.
- Top level `alu_mdu`: the combinational ALU plus one `mdu_core` instance.

## Test plan
- WIDTH=32, mult with a=0xFFFFFFFD (−3), b=7 -> `done` in cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- divu 100/7 -> lo=14, hi=2. div −7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu a=5, b=0 -> `busy` in cycle 1 only, `done` in cycle 2; lo=0xFFFFFFFF, hi=5.
- ALU checks:
  - sub 5−5 -> result=0, zero=1.
  - add 0x7FFFFFFF+1 -> overflow=1.
  - slt 0xFFFFFFFF vs 1 -> result=1.
  - sltu same operands -> result=0.
  - Repeat with WIDTH=8.
- Protocol checks:
  - `md_start` and `hi_we` pulsed during RUN -> ignored; HI holds the first result.
  - `hi_we` with a=0x1234 in IDLE -> hi=0x1234 next cycle.
- Reset: `rst_n` low in cycle 10 of a multu -> next cycle busy=0, hi=lo=0, no `done` pulse ever follows.
